// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus host arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_arb_pkg;

  typedef enum logic [0:0] {
    ArbIdle     = 1'b0,
    ArbWaitResp = 1'b1
  } arb_state_e;

  // Lowest bit of slice idx in a packed vector made of width-bit slices.
  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, cyclic.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides whether the pick is used.
// Ports: req (per-host requests), ptr (priority start index),
//        gnt (one-hot pick or zero), idx (picked index), vld (any pick).
module rr_arbiter #(
  parameter int N    = 2,
  parameter int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx,
  output logic            vld
);

  always_comb begin
    int k;
    k   = 0;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + i) % N;
      if (!vld && req[k]) begin
        vld    = 1'b1;
        idx    = IdxW'(k);
        gnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_host_arbiter.sv
// Shares one device request channel among NrHosts hosts, one transaction in flight.
// Latency: grant and device request same cycle; response routed to owner same cycle.
// Backpressure: hosts wait (no grant) while a transaction is outstanding; silent device -> timeout error.
// Ports: host_* per-host request/grant/response (packed slices, host i at slice i),
//        dev_* single device channel, busy_o outstanding flag, timeout_o timeout pulse.
module bus_host_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NrHosts       = 2,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NrHosts-1:0]              host_req_i,
  output logic [NrHosts-1:0]              host_gnt_o,
  input  logic [NrHosts*AddressWidth-1:0] host_addr_i,
  input  logic [NrHosts-1:0]              host_we_i,
  input  logic [NrHosts*DataWidth/8-1:0]  host_be_i,
  input  logic [NrHosts*DataWidth-1:0]    host_wdata_i,
  output logic [NrHosts-1:0]              host_rvalid_o,
  output logic [DataWidth-1:0]            host_rdata_o,
  output logic [NrHosts-1:0]              host_err_o,
  output logic                            dev_req_o,
  output logic [AddressWidth-1:0]         dev_addr_o,
  output logic                            dev_we_o,
  output logic [DataWidth/8-1:0]          dev_be_o,
  output logic [DataWidth-1:0]            dev_wdata_o,
  input  logic                            dev_rvalid_i,
  input  logic [DataWidth-1:0]            dev_rdata_i,
  input  logic                            dev_err_i,
  output logic                            busy_o,
  output logic                            timeout_o
);

  localparam int IdxW = $clog2(NrHosts);
  localparam int BeW  = DataWidth / 8;
  // Width 1 when the timeout is disabled so the counter stays legal.
  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  arb_state_e      state_q;
  logic [IdxW-1:0] owner_q;
  logic [IdxW-1:0] ptr_q;
  logic [CntW-1:0] cnt_q;

  logic [NrHosts-1:0] pick_oh;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_vld;
  logic               arb_en;
  logic               grant;
  logic               timeout_hit;
  logic               rsp_vld;

  rr_arbiter #(.N(NrHosts), .IdxW(IdxW)) u_rr (
    .req (host_req_i),
    .ptr (ptr_q),
    .gnt (pick_oh),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // Arbitration runs in IDLE and in the response cycle, enabling back-to-back
  // transactions. Everything is gated by rst_ni so outputs are quiet in reset.
  assign arb_en      = (state_q == ArbIdle) || ((state_q == ArbWaitResp) && dev_rvalid_i);
  assign grant       = rst_ni && arb_en && pick_vld;
  assign timeout_hit = rst_ni && (TimeoutCycles != 0) && (state_q == ArbWaitResp)
                       && !dev_rvalid_i && (cnt_q == CntLast);
  assign rsp_vld     = rst_ni && (state_q == ArbWaitResp) && (dev_rvalid_i || timeout_hit);

  always_comb begin
    host_gnt_o    = '0;
    dev_req_o     = 1'b0;
    dev_addr_o    = '0;
    dev_we_o      = 1'b0;
    dev_be_o      = '0;
    dev_wdata_o   = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    if (grant) begin
      host_gnt_o  = pick_oh;
      dev_req_o   = 1'b1;
      dev_addr_o  = host_addr_i[slice_lsb(int'(pick_idx), AddressWidth) +: AddressWidth];
      dev_we_o    = host_we_i[pick_idx];
      dev_be_o    = host_be_i[slice_lsb(int'(pick_idx), BeW) +: BeW];
      dev_wdata_o = host_wdata_i[slice_lsb(int'(pick_idx), DataWidth) +: DataWidth];
    end
    for (int i = 0; i < NrHosts; i++) begin
      if (rsp_vld && (owner_q == IdxW'(i))) begin
        host_rvalid_o[i] = 1'b1;
        host_err_o[i]    = dev_rvalid_i ? dev_err_i : 1'b1;
      end
    end
    // Timeout responses carry zero data.
    if (rsp_vld && dev_rvalid_i) host_rdata_o = dev_rdata_i;
  end

  assign busy_o    = rst_ni && (state_q == ArbWaitResp);
  assign timeout_o = timeout_hit;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ArbIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else if (grant) begin
      state_q <= ArbWaitResp;
      owner_q <= pick_idx;
      ptr_q   <= (pick_idx == IdxW'(NrHosts - 1)) ? '0 : pick_idx + 1'b1;
      cnt_q   <= '0;
    end else if (state_q == ArbWaitResp) begin
      if (dev_rvalid_i || timeout_hit) begin
        state_q <= ArbIdle;
      end else if (cnt_q != '1) begin
        // Saturate so a disabled or very long timeout never wraps.
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_host_arbiter.sv
module tb_bus_host_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // Two-host instance with short timeout.
  logic [1:0]  req, gnt, rvalid, err;
  logic [63:0] addr, wdata;
  logic [1:0]  we;
  logic [7:0]  be;
  logic [31:0] rdata;
  logic        dev_req, dev_we, dev_rvalid, dev_err, busy, tmo;
  logic [31:0] dev_addr, dev_wdata, dev_rdata;
  logic [3:0]  dev_be;

  // Three-host instance with timeout disabled.
  logic [2:0]  req3, gnt3, rvalid3, err3, we3;
  logic [95:0] addr3, wdata3;
  logic [11:0] be3;
  logic [31:0] rdata3, dev_addr3, dev_wdata3, dev_rdata3;
  logic [3:0]  dev_be3;
  logic        dev_req3, dev_we3, dev_rvalid3, dev_err3, busy3, tmo3;

  bus_host_arbiter #(.NrHosts(2), .DataWidth(32), .AddressWidth(32), .TimeoutCycles(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(req), .host_gnt_o(gnt), .host_addr_i(addr), .host_we_i(we),
    .host_be_i(be), .host_wdata_i(wdata), .host_rvalid_o(rvalid), .host_rdata_o(rdata),
    .host_err_o(err), .dev_req_o(dev_req), .dev_addr_o(dev_addr), .dev_we_o(dev_we),
    .dev_be_o(dev_be), .dev_wdata_o(dev_wdata), .dev_rvalid_i(dev_rvalid),
    .dev_rdata_i(dev_rdata), .dev_err_i(dev_err), .busy_o(busy), .timeout_o(tmo)
  );

  bus_host_arbiter #(.NrHosts(3), .DataWidth(32), .AddressWidth(32), .TimeoutCycles(0)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .host_req_i(req3), .host_gnt_o(gnt3), .host_addr_i(addr3), .host_we_i(we3),
    .host_be_i(be3), .host_wdata_i(wdata3), .host_rvalid_o(rvalid3), .host_rdata_o(rdata3),
    .host_err_o(err3), .dev_req_o(dev_req3), .dev_addr_o(dev_addr3), .dev_we_o(dev_we3),
    .dev_be_o(dev_be3), .dev_wdata_o(dev_wdata3), .dev_rvalid_i(dev_rvalid3),
    .dev_rdata_i(dev_rdata3), .dev_err_i(dev_err3), .busy_o(busy3), .timeout_o(tmo3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; dev_rvalid = 1'b0; dev_err = 1'b0;
    req3 = '0; dev_rvalid3 = 1'b0; dev_err3 = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 2'b11;
    cyc(); cyc();
    #1;
    total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b want=00", gnt); end
    total++; if (dev_req !== 1'b0) begin bad++; $display("FAIL reset_dev_req got=%b want=0", dev_req); end
    total++; if (busy !== 1'b0 || rvalid !== 2'b00 || tmo !== 1'b0) begin
      bad++; $display("FAIL reset_status got busy=%b rvalid=%b tmo=%b want 0/00/0", busy, rvalid, tmo);
    end
    total++; if (dev_addr !== 32'h0 || rdata !== 32'h0) begin
      bad++; $display("FAIL reset_data got addr=%h rdata=%h want 0/0", dev_addr, rdata);
    end
    req = 2'b00;
    cyc();
    rst_n = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_single();
    req = 2'b01; addr = {32'h2000_0000, 32'h8000_0000}; we = 2'b00; be = 8'hFF;
    #1;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL single_gnt got=%b want=01", gnt); end
    total++; if (dev_req !== 1'b1 || dev_addr !== 32'h8000_0000 || dev_we !== 1'b0) begin
      bad++; $display("FAIL single_dev got req=%b addr=%h we=%b want 1/80000000/0", dev_req, dev_addr, dev_we);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy0 got=%b want=0", busy); end
    cyc();
    req = 2'b00; dev_rvalid = 1'b1; dev_rdata = 32'hDEAD_BEEF;
    #1;
    total++; if (rvalid !== 2'b01 || rdata !== 32'hDEAD_BEEF || err !== 2'b00) begin
      bad++; $display("FAIL single_rsp got rvalid=%b rdata=%h err=%b want 01/deadbeef/00", rvalid, rdata, err);
    end
    total++; if (busy !== 1'b1 || gnt !== 2'b00 || dev_addr !== 32'h0) begin
      bad++; $display("FAIL single_busy1 got busy=%b gnt=%b daddr=%h want 1/00/0", busy, gnt, dev_addr);
    end
    cyc();
    dev_rvalid = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || rvalid !== 2'b00 || rdata !== 32'h0) begin
      bad++; $display("FAIL single_done got busy=%b rvalid=%b rdata=%h want 0/00/0", busy, rvalid, rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_owner;
    logic [1:0]  exp_g;
    logic [31:0] exp_a;
    do_reset();
    addr = {32'h2000_0000, 32'h1000_0000};
    req = 2'b11;
    #1;
    total++; if (gnt !== 2'b01 || dev_addr !== 32'h1000_0000) begin
      bad++; $display("FAIL b2b_first got gnt=%b addr=%h want 01/10000000", gnt, dev_addr);
    end
    exp_owner = 2'b01;
    for (int i = 0; i < 4; i++) begin
      cyc();
      dev_rvalid = 1'b1; dev_rdata = 32'h1000 + i;
      #1;
      exp_g = (exp_owner == 2'b01) ? 2'b10 : 2'b01;
      exp_a = (exp_g == 2'b10) ? 32'h2000_0000 : 32'h1000_0000;
      total++; if (rvalid !== exp_owner || rdata !== 32'h1000 + i) begin
        bad++; $display("FAIL b2b_rsp%0d got rvalid=%b rdata=%h want %b/%h", i, rvalid, rdata, exp_owner, 32'h1000 + i);
      end
      total++; if (gnt !== exp_g || dev_addr !== exp_a || busy !== 1'b1) begin
        bad++; $display("FAIL b2b_gnt%0d got gnt=%b addr=%h busy=%b want %b/%h/1", i, gnt, dev_addr, busy, exp_g, exp_a);
      end
      exp_owner = exp_g;
    end
    cyc();
    req = 2'b00; dev_rvalid = 1'b1; dev_rdata = 32'h5A5A;
    #1;
    total++; if (rvalid !== exp_owner || gnt !== 2'b00) begin
      bad++; $display("FAIL b2b_drain got rvalid=%b gnt=%b want %b/00", rvalid, gnt, exp_owner);
    end
    cyc();
    dev_rvalid = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
  endtask

  // Pointer now 1 (last grant went to host0).
  task automatic test_timeout();
    req = 2'b10; we = 2'b10; wdata = {32'hCAFE_0001, 32'h0}; be = 8'hF0;
    #1;
    total++; if (gnt !== 2'b10 || dev_we !== 1'b1 || dev_wdata !== 32'hCAFE_0001 || dev_be !== 4'hF) begin
      bad++; $display("FAIL tmo_gnt got gnt=%b we=%b wd=%h be=%h want 10/1/cafe0001/f", gnt, dev_we, dev_wdata, dev_be);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc();
      req = (i == 4) ? 2'b01 : 2'b00;
      #1;
      if (i < 4) begin
        total++; if (tmo !== 1'b0 || rvalid !== 2'b00 || busy !== 1'b1) begin
          bad++; $display("FAIL tmo_wait%0d got tmo=%b rvalid=%b busy=%b want 0/00/1", i, tmo, rvalid, busy);
        end
      end else begin
        total++; if (tmo !== 1'b1 || rvalid !== 2'b10 || err !== 2'b10 || rdata !== 32'h0) begin
          bad++; $display("FAIL tmo_hit got tmo=%b rvalid=%b err=%b rdata=%h want 1/10/10/0", tmo, rvalid, err, rdata);
        end
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL tmo_nogrant got gnt=%b want 00", gnt); end
      end
    end
    cyc();
    req = 2'b00; dev_rvalid = 1'b1; dev_rdata = 32'h5555_5555;
    #1;
    total++; if (rvalid !== 2'b00 || rdata !== 32'h0 || busy !== 1'b0 || tmo !== 1'b0) begin
      bad++; $display("FAIL tmo_late got rvalid=%b rdata=%h busy=%b tmo=%b want 00/0/0/0", rvalid, rdata, busy, tmo);
    end
    cyc();
    dev_rvalid = 1'b0; we = 2'b00;
  endtask

  // Pointer now 0 (timeout leaves it after host1).
  task automatic test_dev_err();
    req = 2'b01;
    #1;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL err_gnt got=%b want=01", gnt); end
    cyc();
    req = 2'b11; dev_rvalid = 1'b1; dev_err = 1'b1; dev_rdata = 32'h0000_0BAD;
    #1;
    total++; if (rvalid !== 2'b01 || err !== 2'b01 || rdata !== 32'h0000_0BAD) begin
      bad++; $display("FAIL err_rsp got rvalid=%b err=%b rdata=%h want 01/01/00000bad", rvalid, err, rdata);
    end
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL err_ptr got gnt=%b want 10", gnt); end
    cyc();
    req = 2'b00; dev_err = 1'b0;
    #1;
    total++; if (rvalid !== 2'b10 || err !== 2'b00) begin
      bad++; $display("FAIL err_next got rvalid=%b err=%b want 10/00", rvalid, err);
    end
    cyc();
    dev_rvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    req = 2'b01;
    #1;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rmid_gnt got=%b want=01", gnt); end
    cyc();
    req = 2'b00;
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmid_busy got=%b want=1", busy); end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; dev_rvalid = 1'b1; dev_rdata = 32'h77;
    #1;
    total++; if (rvalid !== 2'b00 || rdata !== 32'h0 || busy !== 1'b0) begin
      bad++; $display("FAIL rmid_late got rvalid=%b rdata=%h busy=%b want 00/0/0", rvalid, rdata, busy);
    end
    cyc();
    dev_rvalid = 1'b0; req = 2'b11;
    #1;
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL rmid_regrant got gnt=%b want 01", gnt); end
    cyc();
    req = 2'b00; dev_rvalid = 1'b1;
    #1;
    total++; if (rvalid !== 2'b01) begin bad++; $display("FAIL rmid_rsp got rvalid=%b want 01", rvalid); end
    cyc();
    dev_rvalid = 1'b0;
  endtask

  task automatic test_three_hosts();
    int tmo_seen;
    do_reset();
    addr3 = {32'hC000_0002, 32'hB000_0001, 32'hA000_0000};
    req3 = 3'b010;
    #1;
    total++; if (gnt3 !== 3'b010) begin bad++; $display("FAIL h3_setup got gnt=%b want 010", gnt3); end
    cyc();
    req3 = 3'b000; dev_rvalid3 = 1'b1;
    #1;
    total++; if (rvalid3 !== 3'b010) begin bad++; $display("FAIL h3_setup_rsp got rvalid=%b want 010", rvalid3); end
    cyc();
    dev_rvalid3 = 1'b0; req3 = 3'b101;
    #1;
    total++; if (gnt3 !== 3'b100 || dev_addr3 !== 32'hC000_0002) begin
      bad++; $display("FAIL h3_ptr2 got gnt=%b addr=%h want 100/c0000002", gnt3, dev_addr3);
    end
    cyc();
    dev_rvalid3 = 1'b1;
    #1;
    total++; if (gnt3 !== 3'b001 || rvalid3 !== 3'b100) begin
      bad++; $display("FAIL h3_wrap got gnt=%b rvalid=%b want 001/100", gnt3, rvalid3);
    end
    cyc();
    req3 = 3'b010;
    #1;
    total++; if (gnt3 !== 3'b010 || rvalid3 !== 3'b001 || dev_addr3 !== 32'hB000_0001) begin
      bad++; $display("FAIL h3_host1 got gnt=%b rvalid=%b addr=%h want 010/001/b0000001", gnt3, rvalid3, dev_addr3);
    end
    cyc();
    req3 = 3'b000; dev_rvalid3 = 1'b0;
    tmo_seen = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (tmo3 !== 1'b0 || rvalid3 !== 3'b000) tmo_seen++;
      cyc();
    end
    total++; if (tmo_seen != 0 || busy3 !== 1'b1) begin
      bad++; $display("FAIL h3_notimeout got events=%0d busy=%b want 0/1", tmo_seen, busy3);
    end
    dev_rvalid3 = 1'b1; dev_rdata3 = 32'h3333_0001;
    #1;
    total++; if (rvalid3 !== 3'b010 || rdata3 !== 32'h3333_0001) begin
      bad++; $display("FAIL h3_late_rsp got rvalid=%b rdata=%h want 010/33330001", rvalid3, rdata3);
    end
    cyc();
    dev_rvalid3 = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    req = '0; addr = '0; we = '0; be = '0; wdata = '0;
    dev_rvalid = 1'b0; dev_rdata = '0; dev_err = 1'b0;
    req3 = '0; addr3 = '0; we3 = '0; be3 = '0; wdata3 = '0;
    dev_rvalid3 = 1'b0; dev_rdata3 = '0; dev_err3 = 1'b0;
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_dev_err();
    test_reset_mid();
    test_three_hosts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
